// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive constants: data width, default oversample ratio and the
// 3-bit RX FSM state encodings also used by the TX controller.
package uart_rx_ctrl_pkg;

    localparam int unsigned DATA_WIDTH          = 8;
    localparam int unsigned UART_OVERSAMPLE_DEF = 16;

    localparam logic [2:0] UART_RX_IDLE   = 3'd0;
    localparam logic [2:0] UART_RX_START  = 3'd1;
    localparam logic [2:0] UART_RX_DATA   = 3'd2;
    localparam logic [2:0] UART_RX_PARITY = 3'd3;
    localparam logic [2:0] UART_RX_STOP   = 3'd4;

endpackage

// File: rtl/parity_checker.sv
// Odd-parity checker: flags an error when the received parity bit equals the
// XOR of the data bits, qualified by the load strobe.
module parity_checker #(
    parameter int unsigned Width = 8
) (
    input  logic             parity_load,
    input  logic             rx_in,
    input  logic [Width-1:0] parallel_in,
    output logic             parity_bit_error
);

    assign parity_bit_error = parity_load & (rx_in == ^parallel_in);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, LSB-first shift-in, optional odd
// parity (enabled by defining UART_PARITY_EN), stop check and valid/ready output.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  overrun_error,
    output logic                  busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);
    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

    logic                  rx_meta_q, rxs_q, rxs_prev_q;
    logic [2:0]            state_q, state_d;
    logic [TickW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  stop_done;
    logic                  handshake;

`ifdef UART_PARITY_EN
    logic par_err_q, par_err_d;
    logic perr_q, perr_d;
    logic parity_load;
    logic parity_bit_error;

    assign parity_load = (state_q == UART_RX_PARITY) && baud_tick && (tick_cnt_q == FullLast);

    parity_checker #(
        .Width(DATA_WIDTH)
    ) u_parity_checker (
        .parity_load     (parity_load),
        .rx_in           (rxs_q),
        .parallel_in     (shift_q),
        .parity_bit_error(parity_bit_error)
    );
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_done  = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d  = par_err_q;
`endif
        case (state_q)
            UART_RX_IDLE: begin
                // Only a 1->0 edge starts a frame, so a stuck-low line never re-triggers.
                if (rxs_prev_q && !rxs_q) begin
                    state_d    = UART_RX_START;
                    tick_cnt_d = '0;
                end
            end
            UART_RX_START: begin
                if (baud_tick) begin
                    if (tick_cnt_q == HalfLast) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxs_q ? UART_RX_IDLE : UART_RX_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            UART_RX_DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_q == FullLast) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxs_q, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_d = '0;
`ifdef UART_PARITY_EN
                            state_d   = UART_RX_PARITY;
`else
                            state_d   = UART_RX_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            UART_RX_PARITY: begin
                if (baud_tick) begin
                    if (tick_cnt_q == FullLast) begin
                        tick_cnt_d = '0;
                        par_err_d  = parity_bit_error;
                        state_d    = UART_RX_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
`endif
            UART_RX_STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_q == FullLast) begin
                        tick_cnt_d = '0;
                        stop_done  = 1'b1;
                        state_d    = UART_RX_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            default: state_d = UART_RX_IDLE;
        endcase
    end

    assign handshake = valid_q && rx_ready;

    // A completion in the same cycle as a handshake replaces the word without overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
`ifdef UART_PARITY_EN
        perr_d  = perr_q;
`endif
        if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (stop_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = ~rxs_q;
`ifdef UART_PARITY_EN
            perr_d  = par_err_q;
`endif
            if (valid_q && !handshake) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= UART_RX_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx_in;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_PARITY_EN
            par_err_q  <= par_err_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign framing_error = ferr_q;
    assign overrun_error = ovr_q;
    assign busy          = (state_q != UART_RX_IDLE);
`ifdef UART_PARITY_EN
    assign parity_error  = perr_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random frames
// compared against a frame-level model of the received word and its flags.
module tb_uart_rx_ctrl;
    import uart_rx_ctrl_pkg::*;

`ifdef UART_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif
    localparam int unsigned Os = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       parity_error, framing_error, overrun_error, busy;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    word_t got[$];

    uart_rx_ctrl #(
        .OVERSAMPLE(Os)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_tick    (baud_tick),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    // Record every word taken by a handshake, and count cycles with rx_valid high.
    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready)
            got.push_back({rx_data, parity_error, framing_error, overrun_error});
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic word_t model(input logic [7:0] d, input logic p, input logic s,
                                    input logic ovr);
        word_t w;
        w.data = d;
        w.perr = ParEn && (p == ^d);
        w.ferr = !s;
        w.ovr  = ovr;
        return w;
    endfunction

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        rx_in = 1'b0;
        wait_ticks(Os);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_ticks(Os);
        end
        if (ParEn) begin
            rx_in = p;
            wait_ticks(Os);
        end
        rx_in = s;
        wait_ticks(Os);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if ({parity_error, framing_error, overrun_error} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {parity_error, framing_error, overrun_error}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        wait_ticks(Os);
    endtask

    task automatic test_good_frame();
        word_t exp;
        int vc0;
        got.delete();
        vc0 = valid_cycles;
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_ticks(Os);
        exp = model(8'hA5, 1'b1, 1'b1, 1'b0);
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL good_count: got %0d want 1", got.size()); end
        else begin
            checks++; if (got[0] !== exp) begin errors++; $display("FAIL good_word: got %h want %h", got[0], exp); end
        end
        checks++; if (valid_cycles - vc0 !== 1) begin
            errors++; $display("FAIL good_valid_width: got %0d want 1", valid_cycles - vc0); end
    endtask

    task automatic test_parity_error();
        word_t exp;
        got.delete();
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_ticks(Os);
        exp = model(8'hA5, 1'b0, 1'b1, 1'b0);
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL par_count: got %0d want 1", got.size()); end
        else begin
            checks++; if (got[0] !== exp) begin errors++; $display("FAIL par_word: got %h want %h", got[0], exp); end
        end
    endtask

    task automatic test_framing();
        word_t exp;
        got.delete();
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_ticks(40 * Os);
        exp = model(8'h3C, 1'b1, 1'b0, 1'b0);
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL frm_count: got %0d want 1", got.size()); end
        else begin
            checks++; if (got[0] !== exp) begin errors++; $display("FAIL frm_word: got %h want %h", got[0], exp); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frm_busy_low_line: got %b want 0", busy); end
        rx_in = 1'b1;
        wait_ticks(Os);
    endtask

    task automatic test_glitch();
        got.delete();
        rx_in = 1'b0;
        wait_ticks(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        rx_in = 1'b1;
        wait_ticks(Os / 2);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
        wait_ticks(2 * Os);
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL glitch_words: got %0d want 0", got.size()); end
    endtask

    task automatic test_overrun();
        word_t exp;
        got.delete();
        rx_ready = 1'b0;
        send_frame(8'h11, ~^8'h11, 1'b1);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11 || overrun_error !== 1'b0) begin
            errors++; $display("FAIL ovr_first: got v=%b d=%h o=%b want v=1 d=11 o=0",
                               rx_valid, rx_data, overrun_error); end
        send_frame(8'h22, ~^8'h22, 1'b1);
        @(negedge clk);
        exp = model(8'h22, ~^8'h22, 1'b1, 1'b1);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        checks++; if ({rx_data, parity_error, framing_error, overrun_error} !== exp) begin
            errors++; $display("FAIL ovr_word: got %h want %h",
                               {rx_data, parity_error, framing_error, overrun_error}, exp); end
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0 || overrun_error !== 1'b0) begin
            errors++; $display("FAIL ovr_clear: got v=%b o=%b want v=0 o=0", rx_valid, overrun_error); end
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL ovr_handshakes: got %0d want 1", got.size()); end
        rx_ready = 1'b1;
        wait_ticks(Os);
    endtask

    task automatic test_reset_midframe();
        word_t exp;
        logic [7:0] d;
        got.delete();
        d = 8'h77;
        rx_in = 1'b0;
        wait_ticks(Os);
        for (int i = 0; i < 3; i++) begin
            rx_in = d[i];
            wait_ticks(Os);
        end
        rx_in = d[3];
        wait_ticks(Os / 2);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_abort: got busy=%b v=%b want 0 0", busy, rx_valid); end
        rx_in = 1'b1;
        wait_ticks(Os);
        rst_n = 1'b1;
        wait_ticks(2 * Os);
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_ticks(Os);
        exp = model(8'h5A, 1'b1, 1'b1, 1'b0);
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL rst_mid_count: got %0d want 1", got.size()); end
        else begin
            checks++; if (got[0] !== exp) begin errors++; $display("FAIL rst_mid_word: got %h want %h", got[0], exp); end
        end
    endtask

    task automatic test_random_frames();
        word_t exp_q[$];
        got.delete();
        rx_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            logic [7:0] d;
            logic p, s;
            int idle;
            d    = 8'($urandom);
            p    = (~^d) ^ ($urandom_range(3) == 0);
            s    = ($urandom_range(3) != 0);
            idle = $urandom_range(2);
            if (!s && idle == 0) idle = 1;
            send_frame(d, p, s);
            exp_q.push_back(model(d, p, s, 1'b0));
            rx_in = 1'b1;
            wait_ticks(idle * Os);
        end
        wait_ticks(Os);
        checks++; if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_word[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the receive datapath: detects the start bit on the oversampled line, shifts in `DATA_WIDTH` data bits LSB-first, and drives `parity_checker` at the parity bit. It also checks the stop bit and presents each received word on a valid/ready interface with parity, framing and overrun status. It sits between the baud-tick generator and the host-side receive buffer.

## Interface

- `OVERSAMPLE`, 16: `baud_tick` pulses per bit period; even, ≥ 4.
- `clk`  input  1  system clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `baud_tick`  input  1  single-cycle oversample strobe (`OVERSAMPLE` per bit).
- `rx_in`  input  1  raw serial line; idle high; asynchronous to `clk`.
- `rx_data`  output  `DATA_WIDTH`  received word; stable while `rx_valid`.
- `rx_valid`  output  1  word available.
- `rx_ready`  input  1  consumer accepts the word on `rx_valid && rx_ready`.
- `parity_error`  output  1  parity mismatch for the presented word.
- `framing_error`  output  1  stop bit sampled low for the presented word.
- `overrun_error`  output  1  sticky; a frame completed while `rx_valid` was still high; cleared on the next accepted handshake.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation

- `rx_in` passes through a 2-FF synchronizer (reset value 1). All references to the line below use the synchronized value, `rxs`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on `rxs` goes to START and clears the tick counter.
  - START: after `OVERSAMPLE/2` ticks, sample `rxs`. If it is 0, go to DATA with the bit counter at 0. If it is 1, treat it as a glitch and return to IDLE.
  - DATA: every `OVERSAMPLE` ticks, shift `rxs` into bit `[DATA_WIDTH-1]` of the shift register with a right shift, so the first bit ends up LSB. After `DATA_WIDTH` bits, go to PARITY.
  - PARITY: every `OVERSAMPLE` ticks, pulse `parity_load` for one `clk`, with `rx_in` of the checker = `rxs` and `parallel_in` = shift register. Register `parity_bit_error` into `par_err_q`, then go to STOP.
  - STOP: every `OVERSAMPLE` ticks, sample `rxs`. Load `rx_data`, `parity_error` (from `par_err_q`) and `framing_error` (`~rxs`). Set `rx_valid`, then go to IDLE.
- Parity is odd: the checker flags an error when the received parity bit equals the XOR of the data bits.
- Output register: `rx_valid` stays high until the handshake.
  - If STOP completes while `rx_valid` is high, the new word overwrites `rx_data` and the flags, `rx_valid` stays 1, and `overrun_error` is set.
- A framing-error frame is still delivered. The next start bit is searched only after `rxs` returns high: IDLE requires a 1→0 edge, so a line held low never re-triggers reception.
- Reset values: `rx_data`=0, `rx_valid`=0, all error outputs 0, `busy`=0, FSM in IDLE, counters 0.

## Timing

- `baud_tick` is the only advancing event; the FSM never moves on a `clk` without a tick, except the IDLE→START transition.
- Sample points are at mid-bit: `OVERSAMPLE/2` ticks after the start edge, then every `OVERSAMPLE` ticks.
- `rx_valid`, `rx_data` and the flags update on the `clk` edge following the stop-bit sample tick. From the start edge on `rxs`, this is `OVERSAMPLE/2 + (DATA_WIDTH+2)*OVERSAMPLE` ticks with parity enabled.
- `rx_valid` falls on the `clk` edge after `rx_valid && rx_ready`.
- If a handshake and a new STOP completion land in the same cycle, the new word wins: `rx_valid` stays 1 and there is no overrun.
- Reset asserted mid-frame aborts immediately to the reset values. The frame in progress is lost, and no `rx_valid` is produced for it.

## Configuration

- `UART_PARITY_EN` defined: the PARITY state exists, `parity_checker` is instantiated, and frames are start + `DATA_WIDTH` + parity + stop.
- `UART_PARITY_EN` undefined: DATA goes directly to STOP, `parity_checker` is not instantiated, and `parity_error` is tied to 0. Frames are start + `DATA_WIDTH` + stop.

## Structure

- `DATA_WIDTH` comes from the shared `uart_params.vh`.
- The following also go in `uart_params.vh`, shared with the TX controller:
  - FSM state encodings (`UART_RX_IDLE` … `UART_RX_STOP`, 3 bits).
  - `UART_OVERSAMPLE_DEF` = 16.
- One sub-module: `parity_checker`, instantiated under `UART_PARITY_EN`.
- Tick counter width is `$clog2(OVERSAMPLE)`; bit counter width is `$clog2(DATA_WIDTH+1)`.

## Test plan

Defaults for all scenarios: `DATA_WIDTH`=8, `OVERSAMPLE`=16, `UART_PARITY_EN` defined.

1. Frame 0xA5, parity 1, stop 1, `rx_ready`=1 → `rx_data`=0xA5, one-cycle `rx_valid`, all error flags 0.
2. Frame 0xA5, parity 0 → `rx_data`=0xA5, `parity_error`=1, `framing_error`=0.
3. Frame 0x3C, parity 1, stop 0 → `framing_error`=1. Line then held low for 40 bit times: no further `rx_valid`.
4. `rxs` low for 4 ticks, then high → START aborts to IDLE, no `rx_valid`, `busy` back to 0 after the mid-start sample.
5. `rx_ready`=0. Send 0x11, then 0x22 → `rx_data`=0x22, `overrun_error`=1. Raise `rx_ready` for one handshake → `rx_valid`=0 and `overrun_error`=0.
6. `rst_n` low during the 4th data bit, released, then frame 0x5A with parity 1 → only 0x5A is delivered, with no error flags.
